term_decoder: RTL and testbench



---
 rtl/term_pkg.sv | 13 +
 rtl/csi_param_acc.sv | 18 +
 rtl/term_decoder.sv | 147 ++++++++++++++
 tb/tb_term_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// term_pkg: shared terminal constants, default geometry and decoder state encoding
package term_pkg;
    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 25;
    localparam logic [7:0] ESC      = 8'h1B;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] SPACE    = 8'h20;
    localparam logic [7:0] LBRACKET = 8'h5B;
    localparam logic [7:0] SEMI     = 8'h3B;
    typedef enum logic [1:0] {S_GROUND, S_ESC, S_CSI, S_SWEEP} dec_state_t;
endpackage

// File: rtl/csi_param_acc.sv
// csi_param_acc: saturating decimal accumulator for one CSI numeric parameter
module csi_param_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dig_v,
    input  logic [3:0] dig,
    output logic [6:0] value
);
    logic [10:0] nxt;
    assign nxt = 11'(value) * 11'd10 + 11'(dig);
    always_ff @(posedge clk) begin
        if (rst || clr)
            value <= '0;
        else if (dig_v)
            value <= (nxt > 11'd127) ? 7'd127 : nxt[6:0];
    end
endmodule

// File: rtl/term_decoder.sv
// term_decoder: decodes received text, C0 controls and CSI sequences into text-buffer writes
module term_decoder
    import term_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_v,
    output logic              o_wen,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_wdata,
    output logic [ADDR_W-1:0] o_cursor,
    output logic              o_busy,
    output logic              o_overrun
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] CLAST = CW'(COLS - 1);
    localparam logic [7:0] RMAX = 8'(ROWS - 1);
    localparam logic [7:0] CMAX = 8'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    dec_state_t        state;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              idx, sw_clr, is_digit, acc_clr;
    logic [ADDR_W-1:0] end_addr, cur, row_end;
    logic [6:0]        p0, p1;
    logic [7:0]        n0, n1, row8, col8, mv_up, mv_dn, mv_rt, mv_lf, h_row, h_col;

    assign cur      = ADDR_W'(32'(row) * COLS + 32'(col));
    assign row_end  = ADDR_W'(32'(row) * COLS + COLS - 1);
    assign o_cursor = cur;
    assign row8     = 8'(row);
    assign col8     = 8'(col);
    assign n0       = (p0 == '0) ? 8'd1 : {1'b0, p0};
    assign n1       = (p1 == '0) ? 8'd1 : {1'b0, p1};
    // relative moves clamp at the screen edges instead of wrapping
    assign mv_up    = (row8 >= n0) ? row8 - n0 : 8'd0;
    assign mv_dn    = (row8 + n0 > RMAX) ? RMAX : row8 + n0;
    assign mv_lf    = (col8 >= n0) ? col8 - n0 : 8'd0;
    assign mv_rt    = (col8 + n0 > CMAX) ? CMAX : col8 + n0;
    assign h_row    = (n0 - 8'd1 > RMAX) ? RMAX : n0 - 8'd1;
    assign h_col    = (n1 - 8'd1 > CMAX) ? CMAX : n1 - 8'd1;
    assign is_digit = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    assign acc_clr  = (state == S_ESC) && i_byte_v && (i_byte == LBRACKET);

    csi_param_acc u_p0 (
        .clk(clk), .rst(rst), .clr(acc_clr),
        .dig_v((state == S_CSI) && i_byte_v && is_digit && !idx),
        .dig(i_byte[3:0]), .value(p0)
    );
    csi_param_acc u_p1 (
        .clk(clk), .rst(rst), .clr(acc_clr),
        .dig_v((state == S_CSI) && i_byte_v && is_digit && idx),
        .dig(i_byte[3:0]), .value(p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_GROUND;
            row       <= '0;
            col       <= '0;
            idx       <= 1'b0;
            sw_clr    <= 1'b0;
            end_addr  <= '0;
            o_wen     <= 1'b0;
            o_addr    <= '0;
            o_wdata   <= '0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_wen     <= 1'b0;
            o_overrun <= 1'b0;
            case (state)
                S_GROUND: if (i_byte_v) begin
                    if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
                        o_wen   <= 1'b1;
                        o_addr  <= cur;
                        o_wdata <= i_byte;
                        col     <= (col == CLAST) ? '0 : col + 1'b1;
                        if (col == CLAST) row <= (row == RLAST) ? '0 : row + 1'b1;
                    end else if (i_byte == CR) col <= '0;
                    else if (i_byte == LF) row <= (row == RLAST) ? '0 : row + 1'b1;
                    else if (i_byte == BS && col != '0) col <= col - 1'b1;
                    else if (i_byte == ESC) state <= S_ESC;
                end
                S_ESC: if (i_byte_v) begin
                    state <= (i_byte == ESC) ? S_ESC : (i_byte == LBRACKET) ? S_CSI : S_GROUND;
                    if (i_byte == LBRACKET) idx <= 1'b0;
                end
                S_CSI: if (i_byte_v) begin
                    if (is_digit) state <= S_CSI;
                    else if (i_byte == SEMI) idx <= 1'b1;
                    else if (i_byte == ESC) state <= S_ESC;
                    else if (i_byte >= 8'h40 && i_byte <= 8'h7E) begin
                        state <= S_GROUND;
                        case (i_byte)
                            "H": begin row <= RW'(h_row); col <= CW'(h_col); end
                            "A": row <= RW'(mv_up);
                            "B": row <= RW'(mv_dn);
                            "C": col <= CW'(mv_rt);
                            "D": col <= CW'(mv_lf);
                            "J": if (p0 == 7'd2) begin
                                state    <= S_SWEEP;
                                sw_clr   <= 1'b1;
                                o_wen    <= 1'b1;
                                o_addr   <= '0;
                                o_wdata  <= SPACE;
                                o_busy   <= 1'b1;
                                end_addr <= LAST_CELL;
                            end
                            "K": begin
                                state    <= S_SWEEP;
                                sw_clr   <= 1'b0;
                                o_wen    <= 1'b1;
                                o_addr   <= cur;
                                o_wdata  <= SPACE;
                                o_busy   <= 1'b1;
                                end_addr <= row_end;
                            end
                            default: ;
                        endcase
                    end else if (i_byte < 8'h30 || i_byte > 8'h7E) state <= S_GROUND;
                end
                S_SWEEP: begin
                    o_overrun <= i_byte_v;
                    // o_addr doubles as the sweep pointer; the first write was issued on entry
                    if (o_addr == end_addr) begin
                        o_busy <= 1'b0;
                        state  <= S_GROUND;
                        if (sw_clr) begin row <= '0; col <= '0; end
                    end else begin
                        o_wen  <= 1'b1;
                        o_addr <= o_addr + 1'b1;
                    end
                end
                default: state <= S_GROUND;
            endcase
        end
    end
endmodule

// File: tb/tb_term_decoder.sv
// tb_term_decoder: randomized and directed checks of term_decoder against a screen-level model
module tb_term_decoder;
    logic       clk = 1'b0, rst = 1'b1, i_byte_v = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       o_wen, o_busy, o_overrun;
    logic [9:0] o_addr, o_cursor;
    logic [7:0] o_wdata;
    int checks = 0, errors = 0;
    int busy_cnt = 0, ovr_cnt = 0;
    logic [17:0] got_q[$], exp_q[$];
    int mst, mr, mc, midx;
    int mp[2];

    always #5 clk = ~clk;

    term_decoder dut (
        .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
        .o_wen(o_wen), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_cursor(o_cursor), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always @(negedge clk) begin
        if (o_wen) got_q.push_back({o_addr, o_wdata});
        if (o_busy) busy_cnt++;
        if (o_overrun) ovr_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic model_reset();
        mst = 0; mr = 0; mc = 0; midx = 0; mp[0] = 0; mp[1] = 0;
    endtask

    // Screen-level behaviour: mst 0 = text, 1 = after ESC, 2 = inside CSI
    task automatic model_byte(input logic [7:0] b);
        int n0, n1, v;
        n0 = (mp[0] == 0) ? 1 : mp[0];
        n1 = (mp[1] == 0) ? 1 : mp[1];
        if (mst == 0) begin
            if (b >= 8'h20 && b <= 8'h7E) begin
                exp_q.push_back({10'(mr * 40 + mc), b});
                mc++;
                if (mc == 40) begin mc = 0; mr = (mr + 1) % 25; end
            end else if (b == 8'h0D) mc = 0;
            else if (b == 8'h0A) mr = (mr + 1) % 25;
            else if (b == 8'h08) mc = (mc > 0) ? mc - 1 : 0;
            else if (b == 8'h1B) mst = 1;
        end else if (mst == 1) begin
            if (b == 8'h5B) begin mst = 2; mp[0] = 0; mp[1] = 0; midx = 0; end
            else if (b != 8'h1B) mst = 0;
        end else begin
            if (b >= 8'h30 && b <= 8'h39) begin
                v = mp[midx] * 10 + int'(b) - 48;
                mp[midx] = (v > 127) ? 127 : v;
            end else if (b == 8'h3B) midx = 1;
            else if (b == 8'h1B) mst = 1;
            else if (b >= 8'h40 && b <= 8'h7E) begin
                mst = 0;
                if (b == 8'h48) begin
                    mr = (n0 - 1 > 24) ? 24 : n0 - 1;
                    mc = (n1 - 1 > 39) ? 39 : n1 - 1;
                end else if (b == 8'h41) mr = (mr - n0 < 0) ? 0 : mr - n0;
                else if (b == 8'h42) mr = (mr + n0 > 24) ? 24 : mr + n0;
                else if (b == 8'h43) mc = (mc + n0 > 39) ? 39 : mc + n0;
                else if (b == 8'h44) mc = (mc - n0 < 0) ? 0 : mc - n0;
                else if (b == 8'h4A && mp[0] == 2) begin
                    for (int a = 0; a < 1000; a++) exp_q.push_back({10'(a), 8'h20});
                    mr = 0; mc = 0;
                end else if (b == 8'h4B)
                    for (int c = mc; c < 40; c++) exp_q.push_back({10'(mr * 40 + c), 8'h20});
            end else if (b < 8'h30 || b > 8'h7E) mst = 0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        @(negedge clk);
        i_byte = b;
        i_byte_v = 1'b1;
        model_byte(b);
        @(negedge clk);
        i_byte_v = 1'b0;
        t = 0;
        while (o_busy && t < 1200) begin @(negedge clk); t++; end
        if (t >= 1200) begin
            checks++; errors++;
            $display("FAIL sweep_timeout o_busy=%0b required 0", o_busy);
        end
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b required 0", o_wen); end
        checks++; if (o_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d required 0", o_addr); end
        checks++; if (o_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata got %h required 0", o_wdata); end
        checks++; if (o_cursor !== 10'd0) begin errors++; $display("FAIL reset_cursor got %0d required 0", o_cursor); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", o_busy); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b required 0", o_overrun); end
        rst = 1'b0;
        model_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_text();
        @(negedge clk);
        i_byte = "A";
        i_byte_v = 1'b1;
        model_byte("A");
        @(negedge clk);
        i_byte_v = 1'b0;
        #1;
        checks++; if (o_wen !== 1'b1) begin errors++; $display("FAIL text_wen got %b required 1", o_wen); end
        checks++; if (o_addr !== 10'd0) begin errors++; $display("FAIL text_addr got %0d required 0", o_addr); end
        checks++; if (o_wdata !== "A") begin errors++; $display("FAIL text_wdata got %h required 41", o_wdata); end
        checks++; if (o_cursor !== 10'd1) begin errors++; $display("FAIL text_cursor1 got %0d required 1", o_cursor); end
        @(negedge clk);
        #1;
        checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL text_wen_pulse got %b required 0", o_wen); end
        send("B");
        checks++; if (o_cursor !== 10'd2) begin errors++; $display("FAIL text_cursor2 got %0d required 2", o_cursor); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL text_nwrites got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL text_write%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 18'h0, exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_cup();
        send(8'h1B);
        send_str("[12;5H");
        checks++; if (o_cursor !== 10'd444) begin errors++; $display("FAIL cup_cursor got %0d required 444", o_cursor); end
        send("x");
        checks++; if (o_cursor !== 10'd445) begin errors++; $display("FAIL cup_after got %0d required 445", o_cursor); end
        checks++; if (got_q.size() != 1 || got_q[0] !== {10'd444, 8'h78}) begin errors++; $display("FAIL cup_write got %0d entries first %h required 1 entry %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {10'd444, 8'h78}); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_wrap();
        send(8'h1B);
        send_str("[25;40H");
        checks++; if (o_cursor !== 10'd999) begin errors++; $display("FAIL wrap_home got %0d required 999", o_cursor); end
        send("z");
        checks++; if (o_cursor !== 10'd0) begin errors++; $display("FAIL wrap_cursor got %0d required 0", o_cursor); end
        checks++; if (got_q.size() != 1 || got_q[0] !== {10'd999, 8'h7A}) begin errors++; $display("FAIL wrap_write got %0d entries first %h required %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {10'd999, 8'h7A}); end
        send(8'h1B);
        send_str("[1;2H");
        send(8'h1B);
        send_str("[3D");
        checks++; if (o_cursor !== 10'd0) begin errors++; $display("FAIL left_clamp got %0d required 0", o_cursor); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_clear();
        int b0, v0, t;
        send(8'h1B);
        send_str("[7;7H");
        got_q.delete(); exp_q.delete();
        send(8'h1B);
        send_str("[2");
        b0 = busy_cnt;
        v0 = ovr_cnt;
        @(negedge clk);
        i_byte = "J";
        i_byte_v = 1'b1;
        model_byte("J");
        @(negedge clk);
        i_byte_v = 1'b0;
        repeat (300) @(negedge clk);
        i_byte = "Q";
        i_byte_v = 1'b1;
        @(negedge clk);
        i_byte_v = 1'b0;
        t = 0;
        while (o_busy && t < 1200) begin @(negedge clk); t++; end
        #1;
        checks++; if (t >= 1200) begin errors++; $display("FAIL clear_timeout o_busy=%b required 0", o_busy); end
        checks++; if (busy_cnt - b0 != 1000) begin errors++; $display("FAIL clear_busy got %0d cycles required 1000", busy_cnt - b0); end
        checks++; if (ovr_cnt - v0 != 1) begin errors++; $display("FAIL clear_overrun got %0d pulses required 1", ovr_cnt - v0); end
        checks++; if (o_cursor !== 10'd0) begin errors++; $display("FAIL clear_cursor got %0d required 0", o_cursor); end
        checks++; if (got_q.size() != 1000) begin errors++; $display("FAIL clear_nwrites got %0d required 1000", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clear_write%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 18'h0, exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_erase_line();
        int b0;
        send(8'h1B);
        send_str("[4;36H");
        checks++; if (o_cursor !== 10'd155) begin errors++; $display("FAIL el_pos got %0d required 155", o_cursor); end
        b0 = busy_cnt;
        send(8'h1B);
        send_str("[K");
        checks++; if (busy_cnt - b0 != 5) begin errors++; $display("FAIL el_busy got %0d cycles required 5", busy_cnt - b0); end
        checks++; if (o_cursor !== 10'd155) begin errors++; $display("FAIL el_cursor got %0d required 155", o_cursor); end
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL el_nwrites got %0d required 5", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL el_write%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 18'h0, exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_sweep();
        send(8'h1B);
        send_str("[2");
        @(negedge clk);
        i_byte = "J";
        i_byte_v = 1'b1;
        @(negedge clk);
        i_byte_v = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_sweep_busy got %b required 0", o_busy); end
        checks++; if (o_wen !== 1'b0) begin errors++; $display("FAIL rst_sweep_wen got %b required 0", o_wen); end
        checks++; if (o_cursor !== 10'd0) begin errors++; $display("FAIL rst_sweep_cursor got %0d required 0", o_cursor); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (got_q.size() != 100) begin errors++; $display("FAIL rst_sweep_nwrites got %0d required 100", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== {10'(i), 8'h20}) begin errors++; $display("FAIL rst_sweep_write%0d got %h required %h", i, got_q[i], {10'(i), 8'h20}); end
        end
        model_reset();
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_unknown();
        send(8'h1B);
        send_str("[9q");
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL unk_nowrite got %0d writes required 0", got_q.size()); end
        send("a");
        checks++; if (got_q.size() != 1 || got_q[0] !== {10'd0, 8'h61}) begin errors++; $display("FAIL unk_write got %0d entries first %h required %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0, {10'd0, 8'h61}); end
        send(8'h1B);
        send_str("[5 b");
        send(8'h1B);
        send(8'h1B);
        send_str("[2C");
        checks++; if (o_cursor !== 10'(mr * 40 + mc)) begin errors++; $display("FAIL abort_cursor got %0d required %0d", o_cursor, mr * 40 + mc); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_nwrites got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_write%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 18'h0, exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        string s = "CDEF";
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            i_byte = s[i];
            i_byte_v = 1'b1;
            model_byte(s[i]);
        end
        @(negedge clk);
        i_byte_v = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (o_cursor !== 10'(mr * 40 + mc)) begin errors++; $display("FAIL b2b_cursor got %0d required %0d", o_cursor, mr * 40 + mc); end
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL b2b_nwrites got %0d required 4", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_write%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 18'h0, exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] alpha[24] = '{"a", "Z", " ", "~", "0", "2", "5", "9", ";", "[",
                                  8'h1B, 8'h1B, 8'h0D, 8'h0A, 8'h08, "A", "B", "C",
                                  "D", "H", "K", "J", "q", 8'h7F};
        logic [7:0] b;
        for (int n = 0; n < 400; n++) begin
            b = alpha[$urandom_range(0, 23)];
            send(b);
            checks++;
            if (o_cursor !== 10'(mr * 40 + mc)) begin errors++; $display("FAIL rand_cursor step %0d byte %h got %0d required %0d", n, b, o_cursor, mr * 40 + mc); end
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_nwrites got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_write%0d got %h required %h", i, (i < got_q.size()) ? got_q[i] : 18'h0, exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_text();
        do_reset();
        test_cup();
        test_wrap();
        test_clear();
        test_erase_line();
        test_reset_mid_sweep();
        test_unknown();
        test_back_to_back();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
